// File: rtl/aap_writeback_pkg.sv
// Shared AAP writeback definitions: halted processor-state code and the
// load-tracker FSM encodings.
package aap_writeback_pkg;

  localparam logic [2:0] STATE_HALTED = 3'd2;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_HELD = 2'd2
  } wb_fsm_t;

endpackage

// File: rtl/aap_wb_load_tracker.sv
// Tracks the single outstanding load: waits for memory data, parks it while
// halted, and abandons it after LOAD_TIMEOUT cycles without data.
module aap_wb_load_tracker
  import aap_writeback_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halted,
  input  logic        issue,
  input  logic [5:0]  issue_num,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        ld_req,
  output logic [5:0]  ld_num,
  output logic [15:0] ld_data,
  output logic        load_err,
  output wb_fsm_t     fsm
);

  localparam logic [7:0] TMO = 8'(LOAD_TIMEOUT);

  logic [7:0]  cnt;
  logic [5:0]  pend_num;
  logic [15:0] held_data;

  assign busy    = (fsm != WB_IDLE);
  // Once the counter has hit the limit the load is dead; late data is dropped.
  assign ld_req  = ((fsm == WB_WAIT) && mem_rvalid && !halted && (cnt != TMO)) ||
                   ((fsm == WB_HELD) && !halted);
  assign ld_num  = pend_num;
  assign ld_data = (fsm == WB_HELD) ? held_data : mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= WB_IDLE;
      cnt       <= 8'd0;
      pend_num  <= 6'd0;
      held_data <= 16'd0;
      load_err  <= 1'b0;
    end else begin
      load_err <= 1'b0;
      case (fsm)
        WB_IDLE: begin
          if (issue) begin
            pend_num <= issue_num;
            cnt      <= 8'd0;
            fsm      <= WB_WAIT;
          end
        end
        WB_WAIT: begin
          if (cnt == TMO) begin
            fsm <= WB_IDLE;
          end else if (mem_rvalid) begin
            if (halted) begin
              held_data <= mem_rdata;
              fsm       <= WB_HELD;
            end else begin
              fsm <= WB_IDLE;
            end
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt + 8'd1 == TMO) load_err <= 1'b1;
          end
        end
        WB_HELD: begin
          if (!halted) fsm <= WB_IDLE;
        end
        default: fsm <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/aap_writeback.sv
// AAP writeback stage: accepts completed instructions, resolves write-port
// collisions (d > b > a) and registers the register-file write ports.
module aap_writeback
  import aap_writeback_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic        ex_valid,
  output logic        ex_stall,
  input  logic        ex_a_we,
  input  logic        ex_b_we,
  input  logic        ex_d_we,
  input  logic [5:0]  ex_a_num,
  input  logic [5:0]  ex_b_num,
  input  logic [5:0]  ex_d_num,
  input  logic [15:0] ex_a_data,
  input  logic [15:0] ex_b_data,
  input  logic [15:0] ex_d_data,
  input  logic        ex_load,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic [5:0]  rega_wregnum,
  output logic [5:0]  regb_wregnum,
  output logic [5:0]  regd_wregnum,
  output logic [15:0] rega_wdata,
  output logic [15:0] regb_wdata,
  output logic [15:0] regd_wdata,
  output logic        rega_we,
  output logic        regb_we,
  output logic        regd_we,
  output logic        load_err
);

  logic        halted, accept, issue;
  logic        keep_a, keep_b;
  logic        busy, ld_req;
  logic [5:0]  ld_num;
  logic [15:0] ld_data;
  wb_fsm_t     load_fsm;

  // Handshake: execute holds ex_* stable while ex_stall is high; a transfer
  // happens in exactly the cycles where ex_valid is high and ex_stall is low.
  assign halted   = (state == STATE_HALTED);
  assign ex_stall = busy || halted;
  assign accept   = ex_valid && !ex_stall;
  assign issue    = accept && ex_load && ex_d_we;

  // A pending-load destination still claims port d for masking purposes.
  assign keep_b = ex_b_we && !(ex_d_we && (ex_d_num == ex_b_num));
  assign keep_a = ex_a_we && !(ex_b_we && (ex_b_num == ex_a_num)) &&
                  !(ex_d_we && (ex_d_num == ex_a_num));

  aap_wb_load_tracker #(.LOAD_TIMEOUT(LOAD_TIMEOUT)) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .halted     (halted),
    .issue      (issue),
    .issue_num  (ex_d_num),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .ld_req     (ld_req),
    .ld_num     (ld_num),
    .ld_data    (ld_data),
    .load_err   (load_err),
    .fsm        (load_fsm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rega_we      <= 1'b0;
      regb_we      <= 1'b0;
      regd_we      <= 1'b0;
      rega_wregnum <= 6'd0;
      regb_wregnum <= 6'd0;
      regd_wregnum <= 6'd0;
      rega_wdata   <= 16'd0;
      regb_wdata   <= 16'd0;
      regd_wdata   <= 16'd0;
    end else begin
      rega_we <= 1'b0;
      regb_we <= 1'b0;
      regd_we <= 1'b0;
      if (accept && keep_a) begin
        rega_we      <= 1'b1;
        rega_wregnum <= ex_a_num;
        rega_wdata   <= ex_a_data;
      end
      if (accept && keep_b) begin
        regb_we      <= 1'b1;
        regb_wregnum <= ex_b_num;
        regb_wdata   <= ex_b_data;
      end
      // ld_req only occurs while busy, so it never coincides with an accept.
      if (ld_req) begin
        regd_we      <= 1'b1;
        regd_wregnum <= ld_num;
        regd_wdata   <= ld_data;
      end else if (accept && ex_d_we && !ex_load) begin
        regd_we      <= 1'b1;
        regd_wregnum <= ex_d_num;
        regd_wdata   <= ex_d_data;
      end
    end
  end

endmodule

// File: tb/tb_aap_writeback.sv
// Directed bench for aap_writeback: a vector table for single-cycle writes and
// collisions, plus hand sequences for load, halt, timeout and reset.
module tb_aap_writeback;
  import aap_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic        ex_valid, ex_stall;
  logic        ex_a_we, ex_b_we, ex_d_we;
  logic [5:0]  ex_a_num, ex_b_num, ex_d_num;
  logic [15:0] ex_a_data, ex_b_data, ex_d_data;
  logic        ex_load, mem_rvalid;
  logic [15:0] mem_rdata;
  logic [5:0]  rega_wregnum, regb_wregnum, regd_wregnum;
  logic [15:0] rega_wdata, regb_wdata, regd_wdata;
  logic        rega_we, regb_we, regd_we, load_err;

  int n_vec = 0;
  int n_bad = 0;

  aap_writeback #(.LOAD_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .state(state), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_a_we(ex_a_we), .ex_b_we(ex_b_we), .ex_d_we(ex_d_we),
    .ex_a_num(ex_a_num), .ex_b_num(ex_b_num), .ex_d_num(ex_d_num),
    .ex_a_data(ex_a_data), .ex_b_data(ex_b_data), .ex_d_data(ex_d_data),
    .ex_load(ex_load), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rega_wregnum(rega_wregnum), .regb_wregnum(regb_wregnum), .regd_wregnum(regd_wregnum),
    .rega_wdata(rega_wdata), .regb_wdata(regb_wdata), .regd_wdata(regd_wdata),
    .rega_we(rega_we), .regb_we(regb_we), .regd_we(regd_we), .load_err(load_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        a_we, b_we, d_we;
    logic [5:0]  a_num, b_num, d_num;
    logic [15:0] a_data, b_data, d_data;
    logic        exp_a, exp_b, exp_d;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_load = 0;
    ex_a_we = 0; ex_b_we = 0; ex_d_we = 0;
    ex_a_num = 0; ex_b_num = 0; ex_d_num = 0;
    ex_a_data = 0; ex_b_data = 0; ex_d_data = 0;
  endtask

  // Driver: present a load to d_num with an optional ordinary a write.
  task automatic drive_load(input logic [5:0] d_num, input logic a_we,
                            input logic [5:0] a_num, input logic [15:0] a_data);
    clear_ex();
    ex_valid = 1; ex_load = 1; ex_d_we = 1; ex_d_num = d_num; ex_d_data = 16'hDEAD;
    ex_a_we = a_we; ex_a_num = a_num; ex_a_data = a_data;
  endtask

  task automatic chk_fsm(input string name, input logic [1:0] exp);
    chk(name, 32'(dut.load_fsm), 32'(exp));
  endtask

  initial begin
    rst = 1; state = 3'd0; mem_rvalid = 0; mem_rdata = 0;
    clear_ex();

    //             a_we b_we d_we a    b    d    a_data    b_data    d_data   exp a b d
    vecs[0] = '{1, 0, 0, 6'd3,  6'd0,  6'd0,  16'h1234, 16'h0000, 16'h0000, 1, 0, 0};
    vecs[1] = '{1, 1, 1, 6'd5,  6'd5,  6'd5,  16'h1111, 16'h2222, 16'h3333, 0, 0, 1};
    vecs[2] = '{1, 1, 1, 6'd7,  6'd7,  6'd8,  16'hA001, 16'hB001, 16'hD001, 0, 1, 1};
    vecs[3] = '{1, 1, 1, 6'd9,  6'd10, 6'd9,  16'hA002, 16'hB002, 16'hD002, 0, 1, 1};
    vecs[4] = '{1, 1, 1, 6'd1,  6'd2,  6'd3,  16'hA003, 16'hB003, 16'hD003, 1, 1, 1};
    vecs[5] = '{0, 1, 1, 6'd4,  6'd4,  6'd4,  16'hA004, 16'hB004, 16'hD004, 0, 0, 1};
    vecs[6] = '{1, 1, 0, 6'd6,  6'd6,  6'd6,  16'hA005, 16'hB005, 16'hD005, 0, 1, 0};
    vecs[7] = '{1, 0, 1, 6'h3F, 6'h3F, 6'h3F, 16'hA006, 16'hB006, 16'hD006, 0, 0, 1};

    // Reset state
    tick(); tick();
    chk("rst_stall", 32'(ex_stall), 0);
    chk("rst_we", {29'd0, rega_we, regb_we, regd_we}, 0);
    chk("rst_nums", {14'd0, rega_wregnum, regb_wregnum, regd_wregnum}, 0);
    chk("rst_adata", 32'(rega_wdata), 0);
    chk("rst_ddata", 32'(regd_wdata), 0);
    chk("rst_err", 32'(load_err), 0);
    chk_fsm("rst_fsm", WB_IDLE);
    state = STATE_HALTED; #1;
    chk("rst_halt_stall", 32'(ex_stall), 1);
    state = 3'd0;
    rst = 0;
    tick();

    // Table: single-cycle writes and collision masking
    for (int i = 0; i < 8; i++) begin
      clear_ex();
      ex_valid = 1;
      ex_a_we = vecs[i].a_we; ex_b_we = vecs[i].b_we; ex_d_we = vecs[i].d_we;
      ex_a_num = vecs[i].a_num; ex_b_num = vecs[i].b_num; ex_d_num = vecs[i].d_num;
      ex_a_data = vecs[i].a_data; ex_b_data = vecs[i].b_data; ex_d_data = vecs[i].d_data;
      #1 chk($sformatf("v%0d_stall", i), 32'(ex_stall), 0);
      tick();
      clear_ex();
      chk($sformatf("v%0d_we", i), {29'd0, rega_we, regb_we, regd_we},
          {29'd0, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_d});
      if (vecs[i].exp_a) chk($sformatf("v%0d_a", i), {10'd0, rega_wregnum, rega_wdata},
                             {10'd0, vecs[i].a_num, vecs[i].a_data});
      if (vecs[i].exp_b) chk($sformatf("v%0d_b", i), {10'd0, regb_wregnum, regb_wdata},
                             {10'd0, vecs[i].b_num, vecs[i].b_data});
      if (vecs[i].exp_d) chk($sformatf("v%0d_d", i), {10'd0, regd_wregnum, regd_wdata},
                             {10'd0, vecs[i].d_num, vecs[i].d_data});
      tick();
      chk($sformatf("v%0d_once", i), {29'd0, rega_we, regb_we, regd_we}, 0);
    end

    // Halted: instruction not accepted
    clear_ex(); ex_valid = 1; ex_a_we = 1; ex_a_num = 6'd20; ex_a_data = 16'h4242;
    state = STATE_HALTED; #1;
    chk("halt_stall", 32'(ex_stall), 1);
    tick();
    chk("halt_no_write", 32'(rega_we), 0);
    clear_ex(); state = 3'd0;
    tick();

    // Load with post-increment: issue N, data at N+3, regd at N+4
    drive_load(6'd2, 1, 6'd1, 16'h0102);
    #1 chk("ld_issue_stall", 32'(ex_stall), 0);
    tick(); clear_ex();                                       // N+1
    chk("ld_a_we", {21'd0, rega_we, rega_wregnum, rega_wdata}, {21'd0, 1'b1, 6'd1, 16'h0102});
    chk("ld_no_d_issue", 32'(regd_we), 0);
    chk("ld_stall1", 32'(ex_stall), 1);
    chk_fsm("ld_fsm_wait", WB_WAIT);
    tick();                                                   // N+2
    chk("ld_stall2", 32'(ex_stall), 1);
    tick();                                                   // N+3
    chk("ld_stall3", 32'(ex_stall), 1);
    mem_rvalid = 1; mem_rdata = 16'hBEEF;
    tick(); mem_rvalid = 0; mem_rdata = 0;                    // N+4
    chk("ld_d_write", {21'd0, regd_we, regd_wregnum, regd_wdata}, {21'd0, 1'b1, 6'd2, 16'hBEEF});
    chk("ld_stall_drop", 32'(ex_stall), 0);
    tick();
    chk("ld_d_once", 32'(regd_we), 0);

    // Halt during load: halt N+1, data N+2, stray data N+4, release N+6
    drive_load(6'd11, 0, 6'd0, 16'h0);
    tick(); clear_ex(); state = STATE_HALTED;                 // N+1
    tick(); mem_rvalid = 1; mem_rdata = 16'hCAFE;             // N+2
    tick(); mem_rvalid = 0; mem_rdata = 0;                    // N+3
    for (int k = 3; k <= 5; k++) begin
      chk_fsm($sformatf("hl_held_n%0d", k), WB_HELD);
      chk($sformatf("hl_no_d_n%0d", k), 32'(regd_we), 0);
      if (k == 4) begin mem_rvalid = 1; mem_rdata = 16'h0BAD; end
      tick(); mem_rvalid = 0; mem_rdata = 0;
    end
    state = 3'd0; #1;                                         // N+6
    chk_fsm("hl_held_n6", WB_HELD);
    chk("hl_stall_n6", 32'(ex_stall), 1);
    chk("hl_no_d_n6", 32'(regd_we), 0);
    tick();                                                   // N+7
    chk("hl_d_write", {21'd0, regd_we, regd_wregnum, regd_wdata}, {21'd0, 1'b1, 6'd11, 16'hCAFE});
    chk_fsm("hl_idle", WB_IDLE);
    tick();
    chk("hl_d_once", 32'(regd_we), 0);

    // Timeout with LOAD_TIMEOUT=4: load_err at N+5, idle from N+6
    drive_load(6'd12, 0, 6'd0, 16'h0);
    tick(); clear_ex();                                       // N+1
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("to_err_low_n%0d", k), 32'(load_err), 0);
      chk($sformatf("to_stall_n%0d", k), 32'(ex_stall), 1);
      tick();
    end
    chk("to_err_pulse", 32'(load_err), 1);                    // N+5
    chk("to_no_d", 32'(regd_we), 0);
    tick();                                                   // N+6
    chk("to_err_once", 32'(load_err), 0);
    chk_fsm("to_idle", WB_IDLE);
    chk("to_stall_low", 32'(ex_stall), 0);
    tick(); tick();                                           // N+8
    mem_rvalid = 1; mem_rdata = 16'h5555;
    tick(); mem_rvalid = 0; mem_rdata = 0;                    // N+9
    chk("to_late_ignored", 32'(regd_we), 0);
    chk_fsm("to_late_idle", WB_IDLE);

    // Reset in WAIT: pending load discarded, late data ignored
    drive_load(6'd13, 1, 6'd14, 16'h7777);
    tick(); clear_ex();
    tick();
    chk_fsm("rw_wait", WB_WAIT);
    rst = 1; #1;
    chk("rw_stall", 32'(ex_stall), 0);
    chk_fsm("rw_fsm", WB_IDLE);
    chk("rw_a_out", {21'd0, rega_we, rega_wregnum, rega_wdata}, 0);
    tick(); rst = 0;
    mem_rvalid = 1; mem_rdata = 16'h9999;
    tick(); mem_rvalid = 0; mem_rdata = 0;
    chk("rw_no_d", {21'd0, regd_we, regd_wregnum, regd_wdata}, 0);
    chk("rw_stall_after", 32'(ex_stall), 0);
    chk("rw_err", 32'(load_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
